sum_uart_sequencer: RTL and testbench

SUM_UART_SEQUENCER -- requirements
Module: sum_uart_sequencer

---
 rtl/sum_uart_sequencer_if.sv | 18 +
 rtl/sum_uart_sequencer.sv | 226 ++++++++++++++++++++++
 tb/tb_sum_uart_sequencer.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sum_uart_sequencer_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : sum_uart_sequencer_if
//  Description : Byte handshake between the sum sequencer and a UART
//                transmitter. The master offers tx_data with tx_start held
//                until the transmitter answers with a rising tx_busy.
//  Revision    : 1.0  initial release
// ============================================================================
interface sum_uart_sequencer_if;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;

  modport master (output tx_data, output tx_start, input tx_busy);
  modport slave  (input tx_data, input tx_start, output tx_busy);
endinterface
`default_nettype wire

// File: rtl/sum_uart_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : sum_uart_sequencer
//  Description : Debounces three pushbuttons, strobes operands A/B into an
//                external 2x4 latch, and on "send" transmits the 5-bit sum
//                q_a+q_b as two ASCII hex digits followed by CR over a
//                start/busy UART handshake.
//  Revision    : 1.0  initial release
// ============================================================================
module sum_uart_sequencer #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        btn_a_n,
  input  logic                        btn_b_n,
  input  logic                        btn_send_n,
  input  logic [3:0]                  q_a,
  input  logic [3:0]                  q_b,
  output logic                        save_a_n,
  output logic                        save_b_n,
  sum_uart_sequencer_if.master        uart,
  output logic                        a_valid,
  output logic                        b_valid,
  output logic                        busy,
  output logic                        err
);

  localparam int               CNT_W      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] C_RUN_DONE = CNT_W'(DEBOUNCE_CYCLES);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_REQ  = 3'd2;
  localparam logic [2:0] S_ACK  = 3'd3;
  localparam logic [2:0] S_WAIT = 3'd4;

  // bit 0 = A, bit 1 = B, bit 2 = send
  logic [2:0] w_btn_raw;
  logic [2:0] w_press;

  assign w_btn_raw = {btn_send_n, btn_b_n, btn_a_n};

  // --------------------------------------------------------------------------
  // Per-button synchronizer, run-length debouncer and press detector.
  // A button is only "armed" once a released level has been accepted after
  // reset, so a button held through reset never produces a press.
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < 3; i++) begin : g_btn
    logic             sync1_q;
    logic             sync2_q;
    logic             last_q;
    logic             deb_q;
    logic             prev_q;
    logic             armed_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] w_run;

    // length of the current run of identical synchronized samples, saturating
    always_comb begin
      if (sync2_q != last_q) begin
        w_run = CNT_W'(1);
      end else if (cnt_q == C_RUN_DONE) begin
        w_run = cnt_q;
      end else begin
        w_run = cnt_q + CNT_W'(1);
      end
    end

    // synchronize, count the run, accept the level once the run is long enough
    always_ff @(posedge clk) begin
      if (!reset_n) begin
        sync1_q <= 1'b1;
        sync2_q <= 1'b1;
        last_q  <= 1'b1;
        deb_q   <= 1'b1;
        prev_q  <= 1'b1;
        armed_q <= 1'b0;
        cnt_q   <= '0;
      end else begin
        sync1_q <= w_btn_raw[i];
        sync2_q <= sync1_q;
        last_q  <= sync2_q;
        cnt_q   <= w_run;
        prev_q  <= deb_q;
        if (w_run == C_RUN_DONE) begin
          deb_q <= sync2_q;
          if (sync2_q) begin
            armed_q <= 1'b1;
          end
        end
      end
    end

    assign w_press[i] = armed_q & prev_q & ~deb_q;
  end

  logic w_ev_a;
  logic w_ev_b;
  logic w_ev_send;

  assign w_ev_a    = w_press[0];
  assign w_ev_b    = w_press[1];
  assign w_ev_send = w_press[2];

  // --------------------------------------------------------------------------
  // Sequencer state and datapath
  // --------------------------------------------------------------------------
  logic [2:0] state_q,   state_d;
  logic [1:0] idx_q,     idx_d;
  logic [4:0] sum_q,     sum_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       a_valid_q, a_valid_d;
  logic       b_valid_q, b_valid_d;
  logic       save_a_q,  save_a_d;
  logic       save_b_q,  save_b_d;
  logic       err_q,     err_d;
  logic [7:0] w_tx_byte;

  // ASCII byte for the current index: high digit, low hex digit, then CR
  always_comb begin
    case (idx_q)
      2'd0:    w_tx_byte = {7'b0011000, sum_q[4]};
      2'd1:    w_tx_byte = (sum_q[3:0] <= 4'd9) ? (8'h30 + {4'h0, sum_q[3:0]})
                                                : (8'h37 + {4'h0, sum_q[3:0]});
      default: w_tx_byte = 8'h0D;
    endcase
  end

  // state register plus all sequencer registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      idx_q     <= 2'd0;
      sum_q     <= 5'd0;
      tx_data_q <= 8'h00;
      a_valid_q <= 1'b0;
      b_valid_q <= 1'b0;
      save_a_q  <= 1'b0;
      save_b_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      sum_q     <= sum_d;
      tx_data_q <= tx_data_d;
      a_valid_q <= a_valid_d;
      b_valid_q <= b_valid_d;
      save_a_q  <= save_a_d;
      save_b_q  <= save_b_d;
      err_q     <= err_d;
    end
  end

  // next-state: button events are only honoured in IDLE, everything else is
  // the three-byte request/acknowledge/wait loop
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    sum_d     = sum_q;
    tx_data_d = tx_data_q;
    a_valid_d = a_valid_q;
    b_valid_d = b_valid_q;
    save_a_d  = 1'b0;
    save_b_d  = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        save_a_d = w_ev_a;
        save_b_d = w_ev_b;
        if (w_ev_a) a_valid_d = 1'b1;
        if (w_ev_b) b_valid_d = 1'b1;
        // a save in the same cycle takes priority and swallows the send
        if (w_ev_send && !w_ev_a && !w_ev_b) begin
          if (a_valid_q && b_valid_q) begin
            state_d = S_LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_LOAD: begin
        sum_d   = {1'b0, q_a} + {1'b0, q_b};
        idx_d   = 2'd0;
        state_d = S_REQ;
      end
      S_REQ: begin
        if (!uart.tx_busy) begin
          tx_data_d = w_tx_byte;
          state_d   = S_ACK;
        end
      end
      S_ACK: begin
        if (uart.tx_busy) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!uart.tx_busy) begin
          if (idx_q == 2'd2) begin
            state_d = S_IDLE;
          end else begin
            idx_d   = idx_q + 2'd1;
            state_d = S_REQ;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // outputs: strobes are active-low views of the registered pulses
  always_comb begin
    save_a_n      = ~save_a_q;
    save_b_n      = ~save_b_q;
    err           = err_q;
    a_valid       = a_valid_q;
    b_valid       = b_valid_q;
    busy          = (state_q != S_IDLE);
    uart.tx_start = (state_q == S_ACK);
    uart.tx_data  = tx_data_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_sum_uart_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_sum_uart_sequencer
//  Description : Self-checking bench: button press driver, operand latch and
//                UART transmitter models, and an ASCII reference for the
//                transmitted sum.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sum_uart_sequencer;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       btn_a_n, btn_b_n, btn_send_n;
  logic [3:0] q_a = 4'd0;
  logic [3:0] q_b = 4'd0;
  logic       save_a_n, save_b_n, a_valid, b_valid, busy, err;

  sum_uart_sequencer_if u_if ();

  sum_uart_sequencer #(.DEBOUNCE_CYCLES(D)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .btn_a_n    (btn_a_n),
    .btn_b_n    (btn_b_n),
    .btn_send_n (btn_send_n),
    .q_a        (q_a),
    .q_b        (q_b),
    .save_a_n   (save_a_n),
    .save_b_n   (save_b_n),
    .uart       (u_if),
    .a_valid    (a_valid),
    .b_valid    (b_valid),
    .busy       (busy),
    .err        (err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // event counters, sampled mid-cycle
  int sa_pulses = 0, sb_pulses = 0, sa_low = 0, both_low = 0;
  int err_cyc = 0, tx_rises = 0, busy_cyc = 0, hold_viol = 0;
  logic sa_prev = 1'b1, sb_prev = 1'b1, tx_prev = 1'b0;

  logic [3:0] pend_a = 4'd0, pend_b = 4'd0;
  int         ack_dly = 2, busy_len = 5;
  logic [7:0] cap[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // monitor plus the external operand latch (captures during a low strobe)
  always @(negedge clk) begin
    if (!save_a_n) sa_low++;
    if (!save_a_n && sa_prev) sa_pulses++;
    if (!save_b_n && sb_prev) sb_pulses++;
    if (!save_a_n && !save_b_n) both_low++;
    if (err) err_cyc++;
    if (u_if.tx_start && !tx_prev) tx_rises++;
    if (busy) busy_cyc++;
    sa_prev = save_a_n;
    sb_prev = save_b_n;
    tx_prev = u_if.tx_start;
    if (!save_a_n) q_a = pend_a;
    if (!save_b_n) q_b = pend_b;
  end

  // UART transmitter model: capture byte, ack after ack_dly, busy for busy_len
  logic [7:0] u_byte;
  bit         u_abort;
  initial begin
    u_if.tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (u_if.tx_start === 1'b1) begin
        u_byte  = u_if.tx_data;
        u_abort = 1'b0;
        cap.push_back(u_byte);
        repeat (ack_dly) begin
          @(negedge clk);
          if (!reset_n) u_abort = 1'b1;
          if (!u_abort && (u_if.tx_start !== 1'b1 || u_if.tx_data !== u_byte)) hold_viol++;
        end
        u_if.tx_busy = 1'b1;
        repeat (busy_len) @(negedge clk);
        u_if.tx_busy = 1'b0;
      end
    end
  end

  // reference: sum printed as two upper-case hex digits and CR
  function automatic logic [7:0] exp_byte(input int a, input int b, input int k);
    string hx;
    int    s;
    hx = "0123456789ABCDEF";
    s  = a + b;
    if (k == 0) return hx[s / 16];
    if (k == 1) return hx[s % 16];
    return 8'h0D;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_btns(input logic [2:0] low);
    btn_a_n    = ~low[0];
    btn_b_n    = ~low[1];
    btn_send_n = ~low[2];
  endtask

  // bouncy press, clean hold, clean release
  task automatic press(input logic [2:0] m);
    int nb;
    nb = $urandom_range(0, 2);
    for (int i = 0; i < nb; i++) begin
      set_btns(m);    tick(1);
      set_btns(3'b0); tick(1);
    end
    set_btns(m);    tick(D + 6);
    set_btns(3'b0); tick(D + 6);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy && k < 1000) begin tick(1); k++; end
    chk("idle_timeout", busy, 0);
  endtask

  task automatic wait_tx(input int target);
    int k;
    k = 0;
    while (tx_rises < target && k < 500) begin tick(1); k++; end
    chk("tx_wait", (tx_rises >= target) ? 1 : 0, 1);
  endtask

  task automatic run_send(input int a, input int b, input int ad, input int bl);
    int t0, h0, e0;
    ack_dly  = ad;
    busy_len = bl;
    if ($urandom_range(0, 1) == 1) begin
      pend_a = 4'(a); pend_b = 4'(b); press(3'b011);
    end else begin
      pend_a = 4'(a); press(3'b001);
      pend_b = 4'(b); press(3'b010);
    end
    t0 = tx_rises; h0 = hold_viol; e0 = err_cyc;
    cap.delete();
    press(3'b100);
    wait_idle();
    chk("nbytes", cap.size(), 3);
    for (int k = 0; k < 3; k++)
      if (k < cap.size()) chk($sformatf("byte%0d a=%0d b=%0d", k, a, b), cap[k], exp_byte(a, b, k));
    chk("tx_starts", tx_rises - t0, 3);
    chk("tx_hold", hold_viol - h0, 0);
    chk("seq_err", err_cyc - e0, 0);
    chk("valid_kept", {a_valid, b_valid}, 2'b11);
  endtask

  int s0, b0, e0, t0, bz0, ab0;
  logic [3:0] ea, eb;

  initial begin
    // reset with every button held down
    reset_n = 1'b0;
    set_btns(3'b111);
    tick(2);
    chk("rst_save_a_n", save_a_n, 1);
    chk("rst_save_b_n", save_b_n, 1);
    chk("rst_tx_start", u_if.tx_start, 0);
    chk("rst_tx_data",  u_if.tx_data, 8'h00);
    chk("rst_valid",    {a_valid, b_valid}, 2'b00);
    chk("rst_busy",     busy, 0);
    chk("rst_err",      err, 0);
    reset_n = 1'b1;
    tick(3 * D + 10);
    set_btns(3'b000);
    tick(2 * D + 6);
    chk("held_no_event", sa_pulses + sb_pulses + err_cyc + busy_cyc, 0);

    // glitch shorter than the debounce window, then a real press
    pend_a = 4'd9;
    btn_a_n = 1'b0; tick(3);
    btn_a_n = 1'b1; tick(2 * D + 6);
    chk("glitch_strobe", sa_pulses, 0);
    chk("glitch_valid", a_valid, 0);
    btn_a_n = 1'b0; tick(10);
    btn_a_n = 1'b1; tick(D + 6);
    chk("a_pulses", sa_pulses, 1);
    chk("a_low_cycles", sa_low, 1);
    chk("a_valid_set", {a_valid, b_valid}, 2'b10);

    // send with only A valid is rejected
    e0 = err_cyc; t0 = tx_rises; bz0 = busy_cyc;
    press(3'b100);
    chk("err_pulse", err_cyc - e0, 1);
    chk("err_no_tx", tx_rises - t0, 0);
    chk("err_stay_idle", busy_cyc - bz0, 0);

    // A and B together strobe in the same cycle
    s0 = sa_pulses; b0 = sb_pulses; ab0 = both_low;
    pend_a = 4'd3; pend_b = 4'd4;
    press(3'b011);
    chk("ab_a", sa_pulses - s0, 1);
    chk("ab_b", sb_pulses - b0, 1);
    chk("ab_same_cycle", both_low - ab0, 1);
    chk("ab_valid", {a_valid, b_valid}, 2'b11);

    // send coincident with A: save done, send dropped silently
    s0 = sa_pulses; e0 = err_cyc; bz0 = busy_cyc;
    pend_a = 4'd5;
    press(3'b101);
    chk("coinc_save", sa_pulses - s0, 1);
    chk("coinc_err", err_cyc - e0, 0);
    chk("coinc_no_seq", busy_cyc - bz0, 0);

    // fixed sums, then randomized operands and UART timing
    run_send(9, 7, 2, 5);
    run_send(15, 15, $urandom_range(1, 4), $urandom_range(1, 6));
    run_send(0, 0, $urandom_range(1, 4), $urandom_range(1, 6));
    for (int r = 0; r < 6; r++)
      run_send($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(1, 4), $urandom_range(1, 6));

    // presses while busy are discarded
    ack_dly = 2; busy_len = 10;
    ea = pend_a; eb = pend_b;
    s0 = sa_pulses; e0 = err_cyc; t0 = tx_rises;
    cap.delete();
    btn_send_n = 1'b0;
    wait_tx(t0 + 1);
    btn_send_n = 1'b1;
    wait_tx(t0 + 2);
    pend_a = ~ea;
    btn_a_n = 1'b0; btn_send_n = 1'b0;
    tick(D + 4);
    btn_a_n = 1'b1; btn_send_n = 1'b1;
    wait_idle();
    tick(20);
    chk("busy_no_strobe", sa_pulses - s0, 0);
    chk("busy_no_err", err_cyc - e0, 0);
    chk("busy_no_queue", tx_rises - t0, 3);
    chk("busy_idle", busy, 0);
    for (int k = 0; k < 3; k++)
      if (k < cap.size()) chk($sformatf("busy_byte%0d", k), cap[k], exp_byte(ea, eb, k));

    // reset during the acknowledge phase of byte 1
    ack_dly = 4; busy_len = 3;
    cap.delete();
    t0 = tx_rises;
    btn_send_n = 1'b0;
    wait_tx(t0 + 2);
    chk("ack_b1_start", u_if.tx_start, 1);
    reset_n = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid_tx_start", u_if.tx_start, 0);
    chk("rst_mid_busy", busy, 0);
    tick(1);
    reset_n = 1'b1;
    btn_send_n = 1'b1;
    tick(60);
    chk("rst_no_more_tx", tx_rises - t0, 2);
    chk("rst_bytes", cap.size(), 2);
    chk("rst_valid_clr", {a_valid, b_valid}, 2'b00);
    chk("rst_end_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
